// File: rtl/seq_adder_n_if.sv
// Handshake bundle for seq_adder_n: request side (start/operands) and
// completion side (busy/done/result flags).
interface seq_adder_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_adder_n.sv
// Digit-serial adder/subtractor: WIDTH-bit add or subtract, DIGIT bits per
// clock LSB first, start/busy/done handshake with a registered result.
module seq_adder_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_adder_n_if.slave bus
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DW   = DIGIT + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic [WIDTH-1:0] w_opa_nxt;
  logic [WIDTH-1:0] w_opb_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_sum_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_carry_nxt;
  logic             w_cout_nxt;
  logic             w_ovf_nxt;
  logic             w_done_nxt;

  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_res_shift;
  logic             w_last;
  logic             w_c_msb;

  // One digit of the ripple, plus the carry that entered its top bit.
  assign w_dsum      = {1'b0, r_opa[DIGIT-1:0]} + {1'b0, r_opb[DIGIT-1:0]} + DW'(r_carry);
  assign w_c_msb     = w_dsum[DIGIT-1] ^ r_opa[DIGIT-1] ^ r_opb[DIGIT-1];
  assign w_res_shift = (r_res >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last      = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~cin, so B is inverted and the carry seeded here.
  always_comb begin
    w_opa_nxt   = r_opa;
    w_opb_nxt   = r_opb;
    w_res_nxt   = r_res;
    w_sum_nxt   = r_sum;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_cout_nxt  = r_cout;
    w_ovf_nxt   = r_ovf;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_opa_nxt   = bus.a;
          w_opb_nxt   = bus.sub ? ~bus.b : bus.b;
          w_carry_nxt = bus.cin ^ bus.sub;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        w_res_nxt   = w_res_shift;
        w_opa_nxt   = r_opa >> DIGIT;
        w_opb_nxt   = r_opb >> DIGIT;
        w_carry_nxt = w_dsum[DIGIT];
        w_cnt_nxt   = r_cnt + CW'(1);
        if (w_last) begin
          w_sum_nxt  = w_res_shift;
          w_cout_nxt = w_dsum[DIGIT];
          w_ovf_nxt  = w_c_msb ^ w_dsum[DIGIT];
          w_done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_opa   <= w_opa_nxt;
      r_opb   <= w_opb_nxt;
      r_res   <= w_res_nxt;
      r_sum   <= w_sum_nxt;
      r_cnt   <= w_cnt_nxt;
      r_carry <= w_carry_nxt;
      r_cout  <= w_cout_nxt;
      r_ovf   <= w_ovf_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: doc/seq_adder_n.md
Name: seq_adder_n

Overview:
- Parametrised multi-cycle adder/subtractor. Computes an N-bit sum DIGIT bits per clock, LSB digit first, using a start/busy/done handshake.
- Successor to the single-bit combinational adder cell. Adds width generalisation, carry-in, subtract mode, signed overflow and a registered result.
- Used wherever a small-area arithmetic unit is acceptable in exchange for latency.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must be 0. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in (add) / borrow-in (sub), captured on accepted start
- sub  input  1  0 = A+B+cin, 1 = A−B−cin, captured on accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result
- cout  output  1  carry-out (add); in sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - FSM returns to IDLE and internal operand/shift registers clear.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN.
  - IDLE: busy = 0. If start = 1 at edge E0:
    - Latch a into opA.
    - Latch opB = sub ? ~b : b.
    - Set carry = cin ^ sub.
    - Clear digit counter to 0 and go to RUN.
  - RUN: busy = 1. At each edge E1..ENDIG, add the low DIGIT bits of opA and opB plus carry.
    - Shift the DIGIT-bit result into the internal result register from the MSB side.
    - Shift opA and opB right by DIGIT and update carry.
    - Increment the counter.
  - At edge ENDIG (counter = NDIG−1):
    - Copy the final internal result into sum. Set cout = final carry.
    - Set ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
    - Assert done for exactly one cycle and go to IDLE (busy = 0).
- Latency: an accepted start at E0 produces done high in the cycle following ENDIG, i.e. NDIG cycles after the start edge. Throughput is one operation per NDIG cycles.
- sum/cout/ovf change only at a completion edge. They hold their values through the next operation until its completion; partial results are never visible.
- start while busy is ignored. Operands, cin and sub changing during RUN have no effect.
- start asserted in the done cycle (state IDLE) is accepted, giving back-to-back operation with no bubble.
- start held high continuously means a new operation is accepted every time IDLE is reached.
- Subtract semantics: A + ~B + ~cin. cout = 1 ⇔ A ≥ B + cin (unsigned).
- WIDTH = 1, DIGIT = 1, cin = 0, sub = 0: sum = a^b and cout = a&b after 1 cycle (half-adder equivalent).
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Test Plan:
- WIDTH=8, DIGIT=1: start with a=8'h0F, b=8'h01, cin=0, sub=0 → busy high for 8 cycles; done pulses once, 8 cycles after the start edge; sum=8'h10, cout=0, ovf=0.
- Carry/overflow cases:
  - a=8'hFF, b=8'h01 → sum=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1.
  - a=8'h0F, b=8'h00, cin=1 → sum=8'h10.
- Subtract cases:
  - a=8'h05, b=8'h07, cin=0, sub=1 → sum=8'hFE, cout=0, ovf=0.
  - a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
  - a=8'h10, b=8'h0F, cin=1 → sum=8'h00, cout=1.
- Handshake:
  - start for 8'h01+8'h02, then pulse start with 8'hAA+8'h55 at cycle 3 → ignored, sum=8'h03.
  - Start asserted again in the done cycle → second op accepted; its done arrives exactly 8 cycles later.
  - sum holds 8'h03 until then.
- Reset mid-operation: drop rst_n asynchronously (between edges) at RUN cycle 4 → busy, done, sum, cout and ovf read 0 before the next edge. After release, a new start with 8'h22+8'h11 gives sum=8'h33 with normal latency.
- Config sweep:
  - WIDTH=8, DIGIT=4: 1000 random {a,b,cin,sub} vs reference model → done 2 cycles after start, all outputs match.
  - WIDTH=1, DIGIT=1: all four {a,b} with cin=0, sub=0 → sum=a^b, cout=a&b, done 1 cycle after start.
